// File: rtl/ddr_arbiter.sv
// ddr_arbiter
//   Two-requester arbiter in front of a single DDR3 controller port.
//   One transaction is in flight at a time. The winner's command is
//   registered onto s_*, held while the controller stalls, and read data
//   is routed back to the requester that issued the read.
//
//   Build option: define DDR_ARB_FIXED_PRIO_EN to give port 0 priority on
//   every tie. Without it, ties alternate between the ports (round-robin).
//
// Ports
//   clk_clk, reset_reset_n         : clock, asynchronous active-low reset
//   mN_address/read/write          : requester N command (read wins if both)
//   mN_writedata/byteenable        : requester N write payload
//   mN_waitrequest                 : low only in the cycle the command is accepted
//   mN_readdata/readdatavalid      : read return, driven only on the granted port
//   s_address/read/write/...       : command to the DDR3 controller
//   s_waitrequest/readdata/...     : controller stall and read return
module ddr_arbiter #(
   parameter int AW = 29,
   parameter int DW = 32
) (
   input  logic            clk_clk,
   input  logic            reset_reset_n,
   input  logic [AW-1:0]   m0_address,
   input  logic            m0_read,
   input  logic            m0_write,
   input  logic [DW-1:0]   m0_writedata,
   input  logic [DW/8-1:0] m0_byteenable,
   output logic            m0_waitrequest,
   output logic [DW-1:0]   m0_readdata,
   output logic            m0_readdatavalid,
   input  logic [AW-1:0]   m1_address,
   input  logic            m1_read,
   input  logic            m1_write,
   input  logic [DW-1:0]   m1_writedata,
   input  logic [DW/8-1:0] m1_byteenable,
   output logic            m1_waitrequest,
   output logic [DW-1:0]   m1_readdata,
   output logic            m1_readdatavalid,
   output logic [AW-1:0]   s_address,
   output logic            s_read,
   output logic            s_write,
   output logic [DW-1:0]   s_writedata,
   output logic [DW/8-1:0] s_byteenable,
   input  logic            s_waitrequest,
   input  logic [DW-1:0]   s_readdata,
   input  logic            s_readdatavalid
);

   typedef enum logic [1:0] {IDLE, CMD, RDWAIT} state_t;

   state_t state, state_nxt;
   logic   grant;
   logic   win;
   logic   req0, req1, any_req;
   logic   win_rd, win_wr;

`ifndef DDR_ARB_FIXED_PRIO_EN
   logic   last_grant;
`endif

   assign req0    = m0_read | m0_write;
   assign req1    = m1_read | m1_write;
   assign any_req = req0 | req1;

   always_comb begin
      win = 1'b0;
`ifdef DDR_ARB_FIXED_PRIO_EN
      win = ~req0;
`else
      // Only a genuine tie consults the history; a lone requester always wins.
      if (req0 && req1) win = ~last_grant;
      else              win = req1;
`endif
   end

   assign win_rd = win ? m1_read  : m0_read;
   assign win_wr = win ? m1_write : m0_write;

   // State register
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) state <= IDLE;
      else                state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (any_req) state_nxt = CMD;
         CMD:     if (!s_waitrequest) state_nxt = s_read ? RDWAIT : IDLE;
         RDWAIT:  if (s_readdatavalid) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      m0_waitrequest   = 1'b1;
      m1_waitrequest   = 1'b1;
      m0_readdata      = '0;
      m1_readdata      = '0;
      m0_readdatavalid = 1'b0;
      m1_readdatavalid = 1'b0;
      if (state == CMD && !s_waitrequest) begin
         if (grant) m1_waitrequest = 1'b0;
         else       m0_waitrequest = 1'b0;
      end
      if (state == RDWAIT) begin
         if (grant) begin
            m1_readdata      = s_readdata;
            m1_readdatavalid = s_readdatavalid;
         end else begin
            m0_readdata      = s_readdata;
            m0_readdatavalid = s_readdatavalid;
         end
      end
   end

   // Command capture and grant bookkeeping
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         grant        <= 1'b0;
         s_address    <= '0;
         s_read       <= 1'b0;
         s_write      <= 1'b0;
         s_writedata  <= '0;
         s_byteenable <= '0;
`ifndef DDR_ARB_FIXED_PRIO_EN
         last_grant   <= 1'b1;
`endif
      end else begin
         if (state == IDLE && any_req) begin
            grant        <= win;
            s_address    <= win ? m1_address    : m0_address;
            s_writedata  <= win ? m1_writedata  : m0_writedata;
            s_byteenable <= win ? m1_byteenable : m0_byteenable;
            s_read       <= win_rd;
            s_write      <= win_wr & ~win_rd;
`ifndef DDR_ARB_FIXED_PRIO_EN
            last_grant   <= win;
`endif
         end else if (state == CMD && !s_waitrequest) begin
            s_read  <= 1'b0;
            s_write <= 1'b0;
         end
      end
   end

endmodule

// File: doc/ddr_arbiter.md
DDR_ARBITER -- requirements
Module: ddr_arbiter

Interface
REQ-001 SHALL have parameter AW, default 29, meaning byte-address width.
REQ-002 SHALL have parameter DW, default 32, meaning data width (multiple of 8).
REQ-003 SHALL have ports clk_clk (in, 1, sole clock) and reset_reset_n (in, 1, reset); one clock, reset asynchronous active-low.
REQ-004 SHALL have, per requester N in {0,1}: mN_address (in, AW, address).
REQ-005 SHALL have mN_read (in, 1, read request) and mN_write (in, 1, write request).
REQ-006 SHALL have mN_writedata (in, DW, write data) and mN_byteenable (in, DW/8, byte lanes).
REQ-007 SHALL have mN_waitrequest (out, 1, stall) and mN_readdata (out, DW, read data).
REQ-008 SHALL have mN_readdatavalid (out, 1, read data valid).
REQ-009 SHALL have s_address (out, AW), s_read (out, 1), s_write (out, 1), s_writedata (out, DW) and s_byteenable (out, DW/8), all driving the shared DDR3 controller port.
REQ-010 SHALL have s_waitrequest (in, 1), s_readdata (in, DW) and s_readdatavalid (in, 1).

Function
REQ-011 SHALL implement FSM states IDLE, CMD, RDWAIT.
REQ-012 In IDLE, SHALL latch the winning requester into grant, capture its command onto s_* registers and enter CMD on the next edge.
REQ-013 A request asserted in IDLE at cycle N SHALL appear on s_read/s_write at cycle N+1.
REQ-014 With both requesting in IDLE, SHALL grant the port not granted last (round-robin); a single requester SHALL always win.
REQ-015 In CMD, SHALL hold all s_* outputs stable while s_waitrequest=1.
REQ-016 In CMD with s_waitrequest=0: a write SHALL pulse m[grant]_waitrequest=0 for exactly that cycle, deassert s_write and return to IDLE.
REQ-017 In CMD with s_waitrequest=0: a read SHALL pulse m[grant]_waitrequest=0 for that cycle, deassert s_read and enter RDWAIT.
REQ-018 In RDWAIT, SHALL forward s_readdata to m[grant]_readdata with m[grant]_readdatavalid=1 in the same cycle s_readdatavalid=1, then return to IDLE.
REQ-019 SHALL hold mN_waitrequest=1 at all times other than the acceptance cycle of REQ-016/REQ-017.
REQ-020 SHALL never drive mN_readdatavalid on the non-granted port.
REQ-021 SHALL allow at most one outstanding transaction.
REQ-022 SHALL not forward requests arriving during CMD or RDWAIT; they wait, stalled, until IDLE.
REQ-023 mN_read and mN_write asserted together SHALL be treated as a read.
REQ-024 SHALL ignore s_readdatavalid outside RDWAIT.

Reset
REQ-025 Asserting reset_reset_n=0 SHALL immediately force IDLE, s_read=0, s_write=0, s_address/s_writedata/s_byteenable=0, mN_waitrequest=1, mN_readdatavalid=0, mN_readdata=0, and last-grant=1, so port 0 wins the first tie.
REQ-026 Reset mid-transaction SHALL abandon it; no readdatavalid SHALL be issued for it after release.

Configuration
REQ-027 With macro DDR_ARB_FIXED_PRIO_EN defined, port 0 SHALL win every tie in IDLE and the last-grant register SHALL be absent; without it, REQ-014 round-robin SHALL apply.

Verification
REQ-028 Write only on m0 (addr 0x100, data 0xDEADBEEF), s_waitrequest=0 -> s_write at N+1 with the same address and data, m0_waitrequest low one cycle, back in IDLE at N+2.
REQ-029 Read on m1 with s_waitrequest high for 3 cycles and readdatavalid 5 cycles after acceptance carrying 0x12345678 -> s_* stable 4 cycles, m1_readdata=0x12345678 with m1_readdatavalid=1 for one cycle, m0_readdatavalid=0 throughout.
REQ-030 Both ports issuing back-to-back writes continuously, 8 transactions -> grants alternate 0,1,0,1...; with DDR_ARB_FIXED_PRIO_EN -> all 8 grants to port 0.
REQ-031 reset_reset_n pulsed low in RDWAIT, then s_readdatavalid=1 after release -> no mN_readdatavalid, all outputs at reset values, next tie granted to port 0.
REQ-032 m0 asserting read and write together at address 0x40 -> only s_read issued, s_write stays 0.
